prog_loader_ctrl: RTL and testbench
===================================

// Module: prog_loader_ctrl
// PURPOSE
//  Boot sequencer for the pipelined core. Receives a byte stream over a valid/ready link,
//  assembles 32-bit little-endian instruction words and writes them to the instruction
//  RAM through the core's inst_address/inst_data/inst_we port. Holds the core in reset
//  (core_rst) until a complete image is loaded, then releases it to execute from BASE_ADDR.
// PARAMETERS
//  BASE_ADDR  32'd0    word address of first instruction written (PC increments by 1/word)
//  DEPTH      32       instruction RAM depth in words; max accepted image length
//  TIMEOUT    1024     idle cycles allowed between bytes mid-load before ERROR (>=2)
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   reset; synchronous, active-high
//  start         in   1   1-cycle pulse: begin a new load (honoured in IDLE, RUN, ERROR only)
//  rx_data       in   8   incoming byte
//  rx_valid      in   1   rx_data valid
//  rx_ready      out  1   loader accepts byte; transfer = rx_valid & rx_ready
//  inst_address  out  32  instruction RAM write address (word index)
//  inst_data     out  32  instruction RAM write data
//  inst_we       out  1   instruction RAM write strobe, 1 cycle per word
//  core_rst      out  1   1 = hold core (drives core reset/clear); 0 = core running
//  busy          out  1   1 in LEN_LO, LEN_HI, DATA, WRITE
//  done          out  1   1-cycle pulse on entry to RUN
//  error         out  1   1 while in ERROR
//  words_loaded  out  16  words written in current/last load
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, core_rst=1, all other outputs 0,
//    internal len/byte/word/timeout counters 0. Reset mid-load aborts with no further writes.
//  - States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, RUN, ERROR.
//  - IDLE: core_rst=1, rx_ready=0. start -> LEN_LO.
//  - LEN_LO: rx_ready=1; on transfer len[7:0]<=rx_data -> LEN_HI.
//  - LEN_HI: rx_ready=1; on transfer len[15:8]<=rx_data; words_loaded<=0; then:
//    len==0 -> RUN; len>DEPTH -> ERROR; else -> DATA with byte_cnt=0.
//  - DATA: rx_ready=1; transfer places rx_data in byte lane byte_cnt (byte 0 = bits 7:0);
//    byte_cnt increments; on 4th byte -> WRITE.
//  - WRITE (exactly 1 cycle): rx_ready=0, inst_we=1,
//    inst_address=BASE_ADDR+words_loaded, inst_data=assembled word; words_loaded++.
//    If words_loaded(new)==len -> RUN else -> DATA. Write is cycle after 4th transfer.
//  - RUN: core_rst=0 from first RUN cycle; done=1 that cycle only. start -> LEN_LO,
//    core_rst=1 from that next cycle on.
//  - ERROR: core_rst=1, error=1, rx_ready=0; start -> LEN_LO (error clears). Image is
//    never partially released: core_rst stays 1 after any error.
//  - Timeout: counter resets on every transfer and on entry to LEN_LO; counts in LEN_LO
//    (after first byte only), LEN_HI, DATA while no transfer; reaching TIMEOUT -> ERROR.
//    LEN_LO waits indefinitely for the first byte.
//  - inst_address/inst_data hold last written values when inst_we=0.
//  - start in LEN_LO/LEN_HI/DATA/WRITE ignored. rx_valid with rx_ready=0 ignored (no drop:
//    source must hold byte). start and transfer in same cycle in IDLE: byte not accepted.
//  - Address arithmetic 32-bit, wraps modulo 2^32 (no wrap within DEPTH if BASE_ADDR valid).
// TESTING
//  1 Reset then idle 10 cycles -> core_rst=1, rx_ready=0, inst_we=0, done=0, error=0.
//  2 start; bytes 02 00 | 13 00 10 00 | 93 00 10 00 -> inst_we pulses @addr 0 data
//    0x00100013, @addr 1 data 0x00100093; done 1 cycle; core_rst=0; words_loaded=2.
//  3 Length bytes 00 00 -> no inst_we, straight to RUN, done pulse, core_rst=0.
//  4 Length 0x0021 (33 > DEPTH=32) -> ERROR, error=1, core_rst=1, no writes; then start
//    and valid 1-word image -> error clears, RUN.
//  5 Image 01 00 then 2 data bytes then stall TIMEOUT cycles -> ERROR, no inst_we, core_rst=1.
//  6 rx_valid toggled randomly during load of 3 words; rst_n asserted after 2nd word ->
//    next cycle IDLE, core_rst=1, no 3rd write; reload succeeds.

Source files
------------

// File: rtl/prog_loader_ctrl_if.sv
// Boot-loader link: byte stream in, instruction RAM write port and core control out.
interface prog_loader_ctrl_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] inst_address;
    logic [31:0] inst_data;
    logic        inst_we;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    // Loader side
    modport master (
        input  start, rx_data, rx_valid,
        output rx_ready, inst_address, inst_data, inst_we,
        output core_rst, busy, done, error, words_loaded
    );

    // Host / byte source / RAM side
    modport slave (
        output start, rx_data, rx_valid,
        input  rx_ready, inst_address, inst_data, inst_we,
        input  core_rst, busy, done, error, words_loaded
    );
endinterface

// File: rtl/prog_loader_ctrl.sv
// Boot sequencer: receives a length-prefixed little-endian byte image, writes it
// word by word into instruction RAM and releases the core only after a full load.
module prog_loader_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic               clk,
    input  logic               rst_n,   // synchronous, active-high
    prog_loader_ctrl_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_RUN, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   wl_q, wl_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   word_q, word_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          rx_ready_q, rx_ready_d;
    logic          inst_we_q, inst_we_d;
    logic          core_rst_q, core_rst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [31:0]   inst_address_q, inst_address_d;
    logic [31:0]   inst_data_q, inst_data_d;

    logic          xfer;
    logic          tmo_hit;
    logic [15:0]   len_full;

    // rx_ready_q mirrors "state accepts bytes", so this is the real handshake
    assign xfer     = bus.rx_valid & rx_ready_q;
    // TIMEOUT consecutive idle cycles have elapsed once the counter sits at TIMEOUT-1
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
    assign len_full = {bus.rx_data, len_q[7:0]};

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q        <= S_IDLE;
            len_q          <= '0;
            wl_q           <= '0;
            byte_cnt_q     <= '0;
            word_q         <= '0;
            tmo_q          <= '0;
            rx_ready_q     <= 1'b0;
            inst_we_q      <= 1'b0;
            core_rst_q     <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            inst_address_q <= '0;
            inst_data_q    <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            wl_q           <= wl_d;
            byte_cnt_q     <= byte_cnt_d;
            word_q         <= word_d;
            tmo_q          <= tmo_d;
            rx_ready_q     <= rx_ready_d;
            inst_we_q      <= inst_we_d;
            core_rst_q     <= core_rst_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            inst_address_q <= inst_address_d;
            inst_data_q    <= inst_data_d;
        end
    end

    // Next-state logic: byte capture, word assembly, length checks and idle timeout
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wl_d       = wl_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        tmo_d      = tmo_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (bus.start) begin
                    state_d = S_LEN_LO;
                    tmo_d   = '0;
                end
            end
            S_LEN_LO: begin
                // first byte may take arbitrarily long: no timeout here
                if (xfer) begin
                    len_d[7:0] = bus.rx_data;
                    tmo_d      = '0;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = bus.rx_data;
                    wl_d        = '0;
                    byte_cnt_d  = '0;
                    tmo_d       = '0;
                    if (len_full == 16'd0)
                        state_d = S_RUN;
                    else if (32'(len_full) > 32'(DEPTH))
                        state_d = S_ERROR;
                    else
                        state_d = S_DATA;
                end else if (tmo_hit) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    tmo_d      = '0;
                    if (byte_cnt_q == 2'd3) begin
                        // count the word now so WRITE can compare against len directly
                        wl_d    = wl_q + 16'd1;
                        state_d = S_WRITE;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WRITE: begin
                state_d = (wl_q == len_q) ? S_RUN : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered-output values derived from the upcoming state
    always_comb begin
        rx_ready_d     = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
        busy_d         = rx_ready_d || (state_d == S_WRITE);
        inst_we_d      = (state_d == S_WRITE);
        core_rst_d     = (state_d != S_RUN);
        done_d         = (state_d == S_RUN) && (state_q != S_RUN);
        error_d        = (state_d == S_ERROR);
        inst_address_d = inst_address_q;
        inst_data_d    = inst_data_q;
        if (inst_we_d) begin
            // wl_q is still the pre-increment index of the word being written
            inst_address_d = BASE_ADDR + 32'(wl_q);
            inst_data_d    = word_d;
        end
    end

    assign bus.rx_ready     = rx_ready_q;
    assign bus.inst_we      = inst_we_q;
    assign bus.inst_address = inst_address_q;
    assign bus.inst_data    = inst_data_q;
    assign bus.core_rst     = core_rst_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.words_loaded = wl_q;
endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Randomized bench for prog_loader_ctrl with an image-level reference model.
module tb_prog_loader_ctrl;
    localparam logic [31:0] BASE  = 32'd0;
    localparam int          DEPTH = 32;
    localparam int          TMO   = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    prog_loader_ctrl_if bus ();

    prog_loader_ctrl #(
        .BASE_ADDR(BASE),
        .DEPTH    (DEPTH),
        .TIMEOUT  (TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Observed RAM writes {addr, data} and done-pulse cycles
    logic [63:0] wr_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (bus.inst_we === 1'b1) begin
            wr_q.push_back({bus.inst_address, bus.inst_data});
            $display("write addr=%08h data=%08h", bus.inst_address, bus.inst_data);
        end
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    // Offer one byte (after optional random idle gaps) and hold it until accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        while (gap > 0 && $urandom_range(99) < gap) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            tick(1);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        budget = 100;
        forever begin
            @(negedge clk);
            if (bus.rx_ready === 1'b1) break;
            budget--;
            if (budget == 0) begin
                n_checks++; n_fail++;
                $display("FAIL send_byte_accept got rx_ready=%b exp 1", bus.rx_ready);
                break;
            end
        end
        tick(1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] img[$], input int gap, input bit do_start);
        if (do_start) start_pulse();
        foreach (img[i]) send_byte(img[i], gap);
    endtask

    // One random image of nw words checked against the model
    task automatic test_random_image(input int nw, input int gap);
        logic [7:0]  img[$];
        logic [63:0] exp;
        int w0 = wr_q.size();
        int d0 = done_cnt;
        img.push_back(8'(nw));
        img.push_back(8'(nw >> 8));
        for (int i = 0; i < 4 * nw; i++) img.push_back(8'($urandom));
        load(img, gap, 1'b1);
        tick(3);
        $display("image nw=%0d gap=%0d loaded", nw, gap);
        n_checks++; if (wr_q.size() - w0 !== nw) begin n_fail++; $display("FAIL img_write_count got %0d exp %0d", wr_q.size() - w0, nw); end
        for (int i = 0; i < nw; i++) begin
            if (w0 + i < wr_q.size()) begin
                exp = {BASE + 32'(i), img[4*i+5], img[4*i+4], img[4*i+3], img[4*i+2]};
                n_checks++; if (wr_q[w0+i] !== exp) begin n_fail++; $display("FAIL img_write[%0d] got %h exp %h", i, wr_q[w0+i], exp); end
            end
        end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL img_done_pulses got %0d exp 1", done_cnt - d0); end
        n_checks++; if (bus.core_rst !== 1'b0) begin n_fail++; $display("FAIL img_core_rst got %b exp 0", bus.core_rst); end
        n_checks++; if (bus.words_loaded !== 16'(nw)) begin n_fail++; $display("FAIL img_words_loaded got %0d exp %0d", bus.words_loaded, nw); end
        n_checks++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL img_error got %b exp 0", bus.error); end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(10);
        $display("reset released, idle 10 cycles");
        n_checks++; if (bus.core_rst !== 1'b1) begin n_fail++; $display("FAIL rst_core_rst got %b exp 1", bus.core_rst); end
        n_checks++; if (bus.rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ready got %b exp 0", bus.rx_ready); end
        n_checks++; if (bus.inst_we !== 1'b0) begin n_fail++; $display("FAIL rst_inst_we got %b exp 0", bus.inst_we); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", bus.done); end
        n_checks++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL rst_error got %b exp 0", bus.error); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        n_checks++; if (bus.words_loaded !== 16'd0) begin n_fail++; $display("FAIL rst_words_loaded got %0d exp 0", bus.words_loaded); end
        n_checks++; if (wr_q.size() !== 0) begin n_fail++; $display("FAIL rst_writes got %0d exp 0", wr_q.size()); end
    endtask

    task automatic test_basic();
        logic [7:0] img[$] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        int w0 = wr_q.size();
        int d0 = done_cnt;
        start_pulse();
        foreach (img[i]) begin
            bus.start = (i >= 2 && i <= 4);   // start while loading must be ignored
            send_byte(img[i], 0);
            bus.start = 1'b0;
            if (i == 3) begin
                n_checks++; if (bus.core_rst !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_midload got core_rst=%b busy=%b exp 1 1", bus.core_rst, bus.busy); end
            end
            if (i == 5) begin
                n_checks++; if (bus.inst_we !== 1'b1) begin n_fail++; $display("FAIL basic_we_timing got %b exp 1", bus.inst_we); end
            end
        end
        tick(3);
        $display("basic image loaded");
        n_checks++; if (wr_q.size() - w0 !== 2) begin n_fail++; $display("FAIL basic_write_count got %0d exp 2", wr_q.size() - w0); end
        if (wr_q.size() - w0 >= 2) begin
            n_checks++; if (wr_q[w0] !== {32'd0, 32'h0010_0013}) begin n_fail++; $display("FAIL basic_write0 got %h exp %h", wr_q[w0], {32'd0, 32'h0010_0013}); end
            n_checks++; if (wr_q[w0+1] !== {32'd1, 32'h0010_0093}) begin n_fail++; $display("FAIL basic_write1 got %h exp %h", wr_q[w0+1], {32'd1, 32'h0010_0093}); end
        end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL basic_done got %0d exp 1", done_cnt - d0); end
        n_checks++; if (bus.core_rst !== 1'b0) begin n_fail++; $display("FAIL basic_core_rst got %b exp 0", bus.core_rst); end
        n_checks++; if (bus.words_loaded !== 16'd2) begin n_fail++; $display("FAIL basic_words_loaded got %0d exp 2", bus.words_loaded); end
        n_checks++; if (bus.inst_address !== 32'd1 || bus.inst_data !== 32'h0010_0093) begin n_fail++; $display("FAIL basic_hold got %h/%h exp 1/00100093", bus.inst_address, bus.inst_data); end
    endtask

    task automatic test_zero_len();
        logic [7:0] img[$] = '{8'h00, 8'h00};
        int w0 = wr_q.size();
        int d0 = done_cnt;
        start_pulse();   // from RUN: core must go back into reset right away
        n_checks++; if (bus.core_rst !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL zero_restart got core_rst=%b busy=%b exp 1 1", bus.core_rst, bus.busy); end
        load(img, 0, 1'b0);
        tick(3);
        $display("zero-length image loaded");
        n_checks++; if (wr_q.size() - w0 !== 0) begin n_fail++; $display("FAIL zero_writes got %0d exp 0", wr_q.size() - w0); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL zero_done got %0d exp 1", done_cnt - d0); end
        n_checks++; if (bus.core_rst !== 1'b0) begin n_fail++; $display("FAIL zero_core_rst got %b exp 0", bus.core_rst); end
        n_checks++; if (bus.words_loaded !== 16'd0) begin n_fail++; $display("FAIL zero_words_loaded got %0d exp 0", bus.words_loaded); end
    endtask

    task automatic test_oversize();
        logic [7:0] img[$] = '{8'h21, 8'h00};
        int w0 = wr_q.size();
        int d0 = done_cnt;
        load(img, 0, 1'b1);
        tick(3);
        $display("oversize length 0x0021 sent");
        n_checks++; if (bus.error !== 1'b1) begin n_fail++; $display("FAIL over_error got %b exp 1", bus.error); end
        n_checks++; if (bus.core_rst !== 1'b1) begin n_fail++; $display("FAIL over_core_rst got %b exp 1", bus.core_rst); end
        n_checks++; if (bus.rx_ready !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL over_ready_busy got %b %b exp 0 0", bus.rx_ready, bus.busy); end
        n_checks++; if (wr_q.size() - w0 !== 0 || done_cnt - d0 !== 0) begin n_fail++; $display("FAIL over_activity got writes=%0d done=%0d exp 0 0", wr_q.size() - w0, done_cnt - d0); end
        test_random_image(1, 0);
    endtask

    task automatic test_timeout();
        logic [7:0] img[$] = '{8'h01, 8'h00, 8'hA5, 8'h5A};
        int w0 = wr_q.size();
        // waiting for the first length byte never times out
        start_pulse();
        tick(3 * TMO);
        n_checks++; if (bus.error !== 1'b0 || bus.rx_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_lenlo_wait got error=%b rx_ready=%b exp 0 1", bus.error, bus.rx_ready); end
        load(img, 0, 1'b0);
        tick(TMO - 2);
        $display("stalled %0d cycles mid-word", TMO - 2);
        n_checks++; if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early got error=%b busy=%b exp 0 1", bus.error, bus.busy); end
        tick(3);
        $display("stalled %0d cycles mid-word", TMO + 1);
        n_checks++; if (bus.error !== 1'b1) begin n_fail++; $display("FAIL tmo_error got %b exp 1", bus.error); end
        n_checks++; if (bus.core_rst !== 1'b1) begin n_fail++; $display("FAIL tmo_core_rst got %b exp 1", bus.core_rst); end
        n_checks++; if (wr_q.size() - w0 !== 0) begin n_fail++; $display("FAIL tmo_writes got %0d exp 0", wr_q.size() - w0); end
        // start is ignored in LEN_LO, so this also exercises a redundant start
        start_pulse();
        test_random_image(2, 30);
    endtask

    task automatic test_reset_midload();
        logic [7:0]  img[$];
        logic [63:0] exp;
        int w0 = wr_q.size();
        img.push_back(8'd3);
        img.push_back(8'd0);
        for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
        start_pulse();
        for (int i = 0; i < 10; i++) send_byte(img[i], 40);
        rst_n = 1'b1;
        tick(1);
        rst_n = 1'b0;
        $display("reset asserted after second word");
        n_checks++; if (bus.core_rst !== 1'b1 || bus.busy !== 1'b0 || bus.rx_ready !== 1'b0) begin n_fail++; $display("FAIL rml_state got core_rst=%b busy=%b rx_ready=%b exp 1 0 0", bus.core_rst, bus.busy, bus.rx_ready); end
        n_checks++; if (bus.words_loaded !== 16'd0 || bus.inst_we !== 1'b0) begin n_fail++; $display("FAIL rml_regs got wl=%0d we=%b exp 0 0", bus.words_loaded, bus.inst_we); end
        // keep offering the rest of the image: IDLE must not take it
        bus.rx_valid = 1'b1;
        for (int i = 10; i < 14; i++) begin bus.rx_data = img[i]; tick(2); end
        bus.rx_valid = 1'b0;
        tick(2);
        n_checks++; if (wr_q.size() - w0 !== 2) begin n_fail++; $display("FAIL rml_write_count got %0d exp 2", wr_q.size() - w0); end
        for (int i = 0; i < 2; i++) begin
            if (w0 + i < wr_q.size()) begin
                exp = {BASE + 32'(i), img[4*i+5], img[4*i+4], img[4*i+3], img[4*i+2]};
                n_checks++; if (wr_q[w0+i] !== exp) begin n_fail++; $display("FAIL rml_write[%0d] got %h exp %h", i, wr_q[w0+i], exp); end
            end
        end
        n_checks++; if (bus.core_rst !== 1'b1) begin n_fail++; $display("FAIL rml_core_rst got %b exp 1", bus.core_rst); end
        test_random_image(3, 40);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) test_random_image(int'($urandom_range(5, 1)), int'($urandom_range(50, 0)));
        test_random_image(DEPTH, 10);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_basic();
        test_zero_len();
        test_oversize();
        test_timeout();
        test_reset_midload();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
